// File: rtl/apb_bridge_responder.sv
// apb_bridge_responder: a_pclk side of the async APB bridge.
// Syncs the request toggle, runs one APB4 transfer, returns a toggle.
module apb_bridge_responder #(
  parameter int ADDR_WD     = 32,
  parameter int DATA_WD     = 32,
  parameter int STRB_WD     = 4,
  parameter int PROT_WD     = 3,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic               a_pclk,
  input  logic               a_prst_n,
  input  logic               req_toggle,
  input  logic               write,
  input  logic [ADDR_WD-1:0] addr,
  input  logic [DATA_WD-1:0] wdata,
  input  logic [PROT_WD-1:0] prot,
  input  logic [STRB_WD-1:0] strb,
  output logic               ready_toggle,
  output logic [DATA_WD-1:0] rdata,
  output logic               slverr,
  output logic               req_overrun,
  output logic               m_psel,
  output logic               m_penable,
  output logic               m_pwrite,
  output logic [ADDR_WD-1:0] m_paddr,
  output logic [DATA_WD-1:0] m_pwdata,
  output logic [PROT_WD-1:0] m_pprot,
  output logic [STRB_WD-1:0] m_pstrb,
  input  logic               m_pready,
  input  logic [DATA_WD-1:0] m_prdata,
  input  logic               m_pslverr
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam logic [15:0] TO_LAST =
    16'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_nx;
  logic        q1;
  logic        q2;
  logic        q3;
  logic        req_edge;
  logic        pending;
  logic [15:0] cnt;
  logic        start;
  logic        done;
  logic        tmo;

  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
      q3 <= 1'b0;
    end else begin
      q1 <= req_toggle;
      q2 <= q1;
      q3 <= q2;
    end
  end

  assign req_edge = q2 ^ q3;

  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_edge || pending) begin
          start    = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: state_nx = ACCESS;
      ACCESS: begin
        if (m_pready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (TIMEOUT_CYC != 0 && cnt == TO_LAST) begin
          done     = 1'b1;
          tmo      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Controls decode straight from state so reset drops them at once
  assign m_psel    = (state != IDLE);
  assign m_penable = (state == ACCESS);

  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) begin
      pending      <= 1'b0;
      req_overrun  <= 1'b0;
      cnt          <= '0;
      ready_toggle <= 1'b0;
      rdata        <= '0;
      slverr       <= 1'b0;
      m_pwrite     <= 1'b0;
      m_paddr      <= '0;
      m_pwdata     <= '0;
      m_pprot      <= '0;
      m_pstrb      <= '0;
    end else begin
      if (req_edge) begin
        if (pending)            req_overrun <= 1'b1;
        else if (state != IDLE) pending     <= 1'b1;
      end
      if (start) begin
        pending  <= 1'b0;
        m_pwrite <= write;
        m_paddr  <= addr;
        m_pwdata <= wdata;
        m_pprot  <= prot;
        m_pstrb  <= write ? strb : '0;
      end
      if (state == SETUP) cnt <= '0;
      else if (state == ACCESS && !m_pready) cnt <= cnt + 16'd1;
      if (done) begin
        ready_toggle <= ~ready_toggle;
        if (tmo) begin
          slverr <= 1'b1;
          if (!m_pwrite) rdata <= '0;
        end else begin
          slverr <= m_pslverr;
          if (!m_pwrite) rdata <= m_prdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_bridge_responder.sv
// tb_apb_bridge_responder: directed and randomized checks of the
// responder against a transaction-level expectation model.
module tb_apb_bridge_responder;

  logic        a_pclk;
  logic        a_prst_n;
  logic        req_toggle;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  prot;
  logic [3:0]  strb;
  logic        ready_toggle;
  logic [31:0] rdata;
  logic        slverr;
  logic        req_overrun;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  logic [2:0]  m_pprot;
  logic [3:0]  m_pstrb;
  logic        m_pready;
  logic [31:0] m_prdata;
  logic        m_pslverr;

  logic        req_toggle0;
  logic        m_pready0;
  logic        ready_toggle0;
  logic [31:0] rdata0;
  logic        slverr0;
  logic        req_overrun0;
  logic        m_psel0;
  logic        m_penable0;
  logic        m_pwrite0;
  logic [31:0] m_paddr0;
  logic [31:0] m_pwdata0;
  logic [2:0]  m_pprot0;
  logic [3:0]  m_pstrb0;

  int          n_chk;
  int          n_fail;
  logic        exp_tog;
  logic [31:0] exp_rdata;
  logic        exp_slverr;

  apb_bridge_responder #(
    .TIMEOUT_CYC(16)
  ) dut (
    .a_pclk(a_pclk), .a_prst_n(a_prst_n),
    .req_toggle(req_toggle), .write(write),
    .addr(addr), .wdata(wdata), .prot(prot), .strb(strb),
    .ready_toggle(ready_toggle), .rdata(rdata),
    .slverr(slverr), .req_overrun(req_overrun),
    .m_psel(m_psel), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_paddr(m_paddr),
    .m_pwdata(m_pwdata), .m_pprot(m_pprot),
    .m_pstrb(m_pstrb), .m_pready(m_pready),
    .m_prdata(m_prdata), .m_pslverr(m_pslverr)
  );

  apb_bridge_responder #(
    .TIMEOUT_CYC(0)
  ) dut0 (
    .a_pclk(a_pclk), .a_prst_n(a_prst_n),
    .req_toggle(req_toggle0), .write(write),
    .addr(addr), .wdata(wdata), .prot(prot), .strb(strb),
    .ready_toggle(ready_toggle0), .rdata(rdata0),
    .slverr(slverr0), .req_overrun(req_overrun0),
    .m_psel(m_psel0), .m_penable(m_penable0),
    .m_pwrite(m_pwrite0), .m_paddr(m_paddr0),
    .m_pwdata(m_pwdata0), .m_pprot(m_pprot0),
    .m_pstrb(m_pstrb0), .m_pready(m_pready0),
    .m_prdata(m_prdata), .m_pslverr(m_pslverr)
  );

  initial a_pclk = 1'b0;
  always #5 a_pclk = ~a_pclk;

  task automatic step();
    @(posedge a_pclk);
    #1;
  endtask

  task automatic test_reset();
    a_prst_n = 1'b0;
    #12;
    n_chk++;
    if ({ready_toggle, rdata, slverr, req_overrun} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_status got %b %h %b %b want 0",
               ready_toggle, rdata, slverr, req_overrun);
    end
    n_chk++;
    if ({m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
         m_pprot, m_pstrb} !== 74'd0) begin
      n_fail++;
      $display("FAIL reset_bus got psel=%b pen=%b addr=%h want 0",
               m_psel, m_penable, m_paddr);
    end
    step();
    a_prst_n = 1'b1;
    step();
  endtask

  task automatic test_read_zero_wait();
    write = 1'b0; addr = 32'h10; strb = 4'hF; prot = 3'h0;
    m_prdata = 32'hDEADBEEF; m_pready = 1'b1; m_pslverr = 1'b0;
    req_toggle = ~req_toggle;
    step(); step();
    n_chk++;
    if (m_psel !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_e2_idle psel=%b want 0", m_psel);
    end
    step();
    n_chk++;
    if ({m_psel, m_penable, m_paddr} !== {2'b10, 32'h10}) begin
      n_fail++;
      $display("FAIL rd_e3_setup psel=%b pen=%b addr=%h want 1 0 10",
               m_psel, m_penable, m_paddr);
    end
    step();
    n_chk++;
    if ({m_psel, m_penable, ready_toggle} !== {2'b11, exp_tog}) begin
      n_fail++;
      $display("FAIL rd_e4_access psel=%b pen=%b tog=%b",
               m_psel, m_penable, ready_toggle);
    end
    step();
    exp_tog = ~exp_tog;
    exp_rdata = 32'hDEADBEEF;
    exp_slverr = 1'b0;
    n_chk++;
    if ({ready_toggle, rdata, slverr, m_pstrb, m_psel} !==
        {exp_tog, exp_rdata, exp_slverr, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL rd_e5_done tog=%b rdata=%h err=%b strb=%h psel=%b",
               ready_toggle, rdata, slverr, m_pstrb, m_psel);
    end
  endtask

  task automatic test_write_wait_err();
    write = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    strb = 4'hF; prot = 3'h2; m_pready = 1'b0; m_pslverr = 1'b0;
    req_toggle = ~req_toggle;
    repeat (3) step();
    n_chk++;
    if ({m_psel, m_pwrite, m_pwdata, m_pstrb, m_pprot} !==
        {2'b11, 32'h12345678, 4'hF, 3'h2}) begin
      n_fail++;
      $display("FAIL wr_setup psel=%b wr=%b wdata=%h strb=%h",
               m_psel, m_pwrite, m_pwdata, m_pstrb);
    end
    repeat (4) step();
    n_chk++;
    if ({ready_toggle, m_penable} !== {exp_tog, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_e7_wait tog=%b pen=%b want %b 1",
               ready_toggle, m_penable, exp_tog);
    end
    m_pready = 1'b1;
    m_pslverr = 1'b1;
    step();
    exp_tog = ~exp_tog;
    exp_slverr = 1'b1;
    n_chk++;
    if ({ready_toggle, slverr, rdata} !==
        {exp_tog, exp_slverr, exp_rdata}) begin
      n_fail++;
      $display("FAIL wr_e8_done tog=%b err=%b rdata=%h want %b 1 %h",
               ready_toggle, slverr, rdata, exp_tog, exp_rdata);
    end
    m_pslverr = 1'b0;
    m_pready = 1'b0;
  endtask

  task automatic test_timeout();
    write = 1'b0; addr = 32'h30; m_prdata = 32'h55;
    m_pready = 1'b0;
    req_toggle = ~req_toggle;
    repeat (4) step();
    repeat (15) step();
    n_chk++;
    if ({ready_toggle, m_penable} !== {exp_tog, 1'b1}) begin
      n_fail++;
      $display("FAIL to_e19_access tog=%b pen=%b want %b 1",
               ready_toggle, m_penable, exp_tog);
    end
    step();
    exp_tog = ~exp_tog;
    exp_slverr = 1'b1;
    exp_rdata = 32'h0;
    n_chk++;
    if ({ready_toggle, slverr, rdata, m_psel} !==
        {exp_tog, exp_slverr, exp_rdata, 1'b0}) begin
      n_fail++;
      $display("FAIL to_e20_done tog=%b err=%b rdata=%h psel=%b",
               ready_toggle, slverr, rdata, m_psel);
    end
  endtask

  task automatic test_timeout_disabled();
    int flips;
    logic prev;
    flips = 0;
    prev = ready_toggle0;
    req_toggle0 = ~req_toggle0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (ready_toggle0 !== prev) flips++;
      prev = ready_toggle0;
    end
    n_chk++;
    if ({flips != 0, m_psel0, m_penable0} !== 3'b011) begin
      n_fail++;
      $display("FAIL to0_hang flips=%0d psel=%b pen=%b want 0 1 1",
               flips, m_psel0, m_penable0);
    end
  endtask

  task automatic test_pending_overrun();
    int comps;
    int at1;
    int at2;
    logic prev;
    logic ps1;
    logic ps2;
    comps = 0; at1 = -1; at2 = -1; ps1 = 1'bx; ps2 = 1'bx;
    write = 1'b0; addr = 32'h40; m_prdata = 32'hA5A50001;
    m_pready = 1'b0; m_pslverr = 1'b0;
    req_toggle = ~req_toggle;
    repeat (4) step();
    req_toggle = ~req_toggle;
    repeat (2) step();
    req_toggle = ~req_toggle;
    repeat (4) step();
    n_chk++;
    if ({req_overrun, ready_toggle} !== {1'b1, exp_tog}) begin
      n_fail++;
      $display("FAIL ovr_flag ovr=%b tog=%b want 1 %b",
               req_overrun, ready_toggle, exp_tog);
    end
    m_pready = 1'b1;
    prev = ready_toggle;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 1) ps1 = m_psel;
      if (i == 2) ps2 = m_psel;
      if (ready_toggle !== prev) begin
        comps++;
        if (comps == 1) at1 = i;
        if (comps == 2) at2 = i;
      end
      prev = ready_toggle;
    end
    exp_rdata = 32'hA5A50001;
    exp_slverr = 1'b0;
    n_chk++;
    if (comps != 2 || at1 != 1 || at2 != 4) begin
      n_fail++;
      $display("FAIL pend_comps got n=%0d at %0d,%0d want 2 at 1,4",
               comps, at1, at2);
    end
    n_chk++;
    if ({ps1, ps2} !== 2'b01) begin
      n_fail++;
      $display("FAIL pend_gap psel seq=%b%b want 01", ps1, ps2);
    end
    n_chk++;
    if ({ready_toggle, rdata, slverr} !==
        {exp_tog, exp_rdata, exp_slverr}) begin
      n_fail++;
      $display("FAIL pend_data tog=%b rdata=%h err=%b",
               ready_toggle, rdata, slverr);
    end
    m_pready = 1'b0;
  endtask

  task automatic test_reset_mid();
    write = 1'b0; addr = 32'h50; m_pready = 1'b0;
    req_toggle = ~req_toggle;
    repeat (4) step();
    #2;
    a_prst_n = 1'b0;
    req_toggle = 1'b0;
    req_toggle0 = 1'b0;
    #1;
    n_chk++;
    if ({m_psel, m_penable, ready_toggle, rdata, req_overrun} !==
        35'd0) begin
      n_fail++;
      $display("FAIL rst_mid psel=%b pen=%b tog=%b rdata=%h ovr=%b",
               m_psel, m_penable, ready_toggle, rdata, req_overrun);
    end
    step();
    a_prst_n = 1'b1;
    exp_tog = 1'b0; exp_rdata = '0; exp_slverr = 1'b0;
    step();
    m_pready = 1'b1; m_prdata = 32'hCAFE0042; addr = 32'h54;
    req_toggle = 1'b1;
    repeat (5) step();
    exp_tog = 1'b1;
    exp_rdata = 32'hCAFE0042;
    n_chk++;
    if ({ready_toggle, rdata, slverr} !==
        {exp_tog, exp_rdata, exp_slverr}) begin
      n_fail++;
      $display("FAIL rst_after tog=%b rdata=%h err=%b want 1 cafe0042 0",
               ready_toggle, rdata, slverr);
    end
    m_pready = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      logic        wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] prd;
      logic [3:0]  s;
      logic [2:0]  p;
      logic        err;
      int          w;
      bit          seen;
      wr = 1'($urandom_range(0, 1));
      a = $urandom; d = $urandom; prd = $urandom;
      s = 4'($urandom_range(0, 15));
      p = 3'($urandom_range(0, 7));
      err = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 9) == 0) ?
          int'($urandom_range(16, 18)) : int'($urandom_range(0, 5));
      write = wr; addr = a; wdata = d; strb = s; prot = p;
      m_pready = 1'b0;
      req_toggle = ~req_toggle;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        step();
        if (m_psel && !m_penable) seen = 1'b1;
      end
      n_chk++;
      if (!seen) begin
        n_fail++;
        $display("FAIL rnd%0d_setup no SETUP within 10 cycles", t);
      end
      n_chk++;
      if ({m_pwrite, m_paddr, m_pwdata, m_pprot, m_pstrb} !==
          {wr, a, d, p, (wr ? s : 4'h0)}) begin
        n_fail++;
        $display("FAIL rnd%0d_payload got %b %h %h %h %h want %b %h %h %h",
                 t, m_pwrite, m_paddr, m_pwdata, m_pprot, m_pstrb,
                 wr, a, d, p);
      end
      step();
      if (w >= 16) begin
        for (int k = 0; k < 16; k++) begin
          m_prdata = $urandom;
          step();
        end
        exp_slverr = 1'b1;
        if (!wr) exp_rdata = '0;
      end else begin
        for (int k = 0; k < w; k++) begin
          m_prdata = $urandom;
          step();
        end
        n_chk++;
        if (ready_toggle !== exp_tog) begin
          n_fail++;
          $display("FAIL rnd%0d_early tog=%b want %b",
                   t, ready_toggle, exp_tog);
        end
        m_pready = 1'b1; m_prdata = prd; m_pslverr = err;
        step();
        exp_slverr = err;
        if (!wr) exp_rdata = prd;
      end
      exp_tog = ~exp_tog;
      n_chk++;
      if ({ready_toggle, rdata, slverr, m_psel} !==
          {exp_tog, exp_rdata, exp_slverr, 1'b0}) begin
        n_fail++;
        $display("FAIL rnd%0d_done w=%0d got %b %h %b %b want %b %h %b 0",
                 t, w, ready_toggle, rdata, slverr, m_psel,
                 exp_tog, exp_rdata, exp_slverr);
      end
      m_pready = 1'b0;
      m_pslverr = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    exp_tog = 1'b0; exp_rdata = '0; exp_slverr = 1'b0;
    req_toggle = 1'b0; req_toggle0 = 1'b0;
    write = 1'b0; addr = '0; wdata = '0; prot = '0; strb = '0;
    m_pready = 1'b0; m_pready0 = 1'b0;
    m_prdata = '0; m_pslverr = 1'b0;
    test_reset();
    test_read_zero_wait();
    test_write_wait_err();
    test_timeout();
    test_timeout_disabled();
    test_pending_overrun();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
